// File: rtl/dac_sif_pkg.sv
// Shared types, sizes and the frame-pack helper for the DAC serial-interface sequencer.
package dac_sif_pkg;

    localparam int unsigned DAC_SIF_ADDR_BITS  = 7;
    localparam int unsigned DAC_SIF_DATA_BITS  = 16;
    localparam int unsigned DAC_SIF_FRAME_BITS = 24;

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        IDLE,
        SHIFT,
        GAP
    } dac_sif_state_t;

    // Write frame: R/W bit (0 = write), then address, then data, MSB first on the wire.
    function automatic logic [DAC_SIF_FRAME_BITS-1:0] pack_write(
        input logic [DAC_SIF_ADDR_BITS-1:0] addr,
        input logic [DAC_SIF_DATA_BITS-1:0] data
    );
        return {1'b0, addr, data};
    endfunction

endpackage

// File: rtl/dac_sif_sequencer_if.sv
// One register-write requester port: valid/ready handshake carrying address and data.
interface dac_sif_sequencer_if;
    import dac_sif_pkg::*;

    logic [DAC_SIF_ADDR_BITS-1:0] addr;
    logic [DAC_SIF_DATA_BITS-1:0] data;
    logic                         valid;
    logic                         ready;

    modport master (output addr, data, valid, input ready);
    modport slave  (input addr, data, valid, output ready);

endinterface

// File: rtl/dac_sif_arb2.sv
// Two-port round-robin grant: a tie goes to the port that was not served last.
module dac_sif_arb2 (
    input  logic [1:0] valid,
    input  logic       last_served,
    input  logic       idle,
    output logic [1:0] ready,
    output logic       grant
);

    // Pick the requester: the lone valid port, or on a tie the one not served last.
    always_comb begin
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_served;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

    // Only the granted, valid port sees ready, and only while the sequencer is idle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = idle && valid[gi] && (grant == (gi != 0));
        end
    endgenerate

endmodule

// File: rtl/dac_sif_sequencer.sv
// DAC serial-interface sequencer: DAC reset sequencing after power-up, then arbitrated
// 24-bit register-write frames shifted out on SDIO/SDENN/SCLK.
module dac_sif_sequencer
    import dac_sif_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RESET_CYCLES = 64,
    parameter int unsigned GAP_CYCLES   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    dac_sif_sequencer_if.slave a,
    dac_sif_sequencer_if.slave b,
    output logic               busy,
    output logic               init_done,
    output logic               DAC_CTRL_SDIO,
    output logic               DAC_CTRL_SDENN,
    output logic               DAC_CTRL_SCLK,
    output logic               DAC_CTRL_RESETN
);

    dac_sif_state_t                state_reg;
    dac_sif_state_t                state_next;
    logic [15:0]                   cnt_reg;
    logic [4:0]                    bit_cnt_reg;
    logic [DAC_SIF_FRAME_BITS-1:0] shift_reg;
    logic                          last_served_reg;
    logic                          sdio_reg;
    logic                          sdenn_reg;
    logic                          sclk_reg;
    logic                          resetn_reg;
    logic                          init_done_reg;

    logic [1:0] valid;
    logic [1:0] ready;
    logic       grant;
    logic       accept;
    logic       hold_done;
    logic       div_done;
    logic       gap_done;
    logic       last_fall;

    assign valid = {b.valid, a.valid};

    dac_sif_arb2 u_arb (
        .valid       (valid),
        .last_served (last_served_reg),
        .idle        (state_reg == IDLE),
        .ready       (ready),
        .grant       (grant)
    );

    assign a.ready = ready[0];
    assign b.ready = ready[1];
    assign accept  = |(valid & ready);

    // One shared counter times the reset phases, the SCLK half-periods and the gap.
    assign hold_done = (cnt_reg == 16'(RESET_CYCLES - 1));
    assign div_done  = (cnt_reg == 16'(CLK_DIV - 1));
    assign gap_done  = (cnt_reg == 16'(GAP_CYCLES - 1));
    // SDENN still high inside SHIFT marks the single set-up cycle before the first bit.
    assign last_fall = !sdenn_reg && div_done && sclk_reg
                       && (bit_cnt_reg == 5'(DAC_SIF_FRAME_BITS - 1));

    assign busy            = (state_reg != IDLE);
    assign init_done       = init_done_reg;
    assign DAC_CTRL_SDIO   = sdio_reg;
    assign DAC_CTRL_SDENN  = sdenn_reg;
    assign DAC_CTRL_SCLK   = sclk_reg;
    assign DAC_CTRL_RESETN = resetn_reg;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= RST_HOLD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RST_HOLD: if (hold_done) state_next = RST_WAIT;
            RST_WAIT: if (hold_done) state_next = IDLE;
            IDLE:     if (accept)    state_next = SHIFT;
            SHIFT:    if (last_fall) state_next = GAP;
            GAP:      if (gap_done)  state_next = IDLE;
            default:                 state_next = RST_HOLD;
        endcase
    end

    // Counters, frame shifter and registered DAC pins; pins lag the state by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg         <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            last_served_reg <= 1'b1;
            sdio_reg        <= 1'b0;
            sdenn_reg       <= 1'b1;
            sclk_reg        <= 1'b0;
            resetn_reg      <= 1'b0;
            init_done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                RST_HOLD: begin
                    if (hold_done) begin
                        cnt_reg    <= '0;
                        resetn_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                RST_WAIT: begin
                    if (hold_done) begin
                        cnt_reg       <= '0;
                        init_done_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        shift_reg       <= grant ? pack_write(b.addr, b.data)
                                                 : pack_write(a.addr, a.data);
                        last_served_reg <= grant;
                        cnt_reg         <= '0;
                        bit_cnt_reg     <= '0;
                    end
                end
                SHIFT: begin
                    if (sdenn_reg) begin
                        sdenn_reg <= 1'b0;
                        sdio_reg  <= shift_reg[DAC_SIF_FRAME_BITS-1];
                        cnt_reg   <= '0;
                    end else if (div_done) begin
                        cnt_reg  <= '0;
                        sclk_reg <= ~sclk_reg;
                        // SDIO only moves on SCLK falling edges.
                        if (sclk_reg) begin
                            if (last_fall) begin
                                sdenn_reg <= 1'b1;
                                sdio_reg  <= 1'b0;
                            end else begin
                                sdio_reg    <= shift_reg[DAC_SIF_FRAME_BITS-2];
                                shift_reg   <= {shift_reg[DAC_SIF_FRAME_BITS-2:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sif_sequencer.sv
// Randomized bench for dac_sif_sequencer against a cycle-number based reference model.
module tb_dac_sif_sequencer;
    import dac_sif_pkg::*;

    localparam int unsigned CLK_DIV      = 4;
    localparam int unsigned RESET_CYCLES = 64;
    localparam int unsigned GAP_CYCLES   = 8;
    localparam int unsigned FRAME_LEN    = 48 * CLK_DIV;

    localparam int MODE_QUIET = 0;
    localparam int MODE_RAND  = 1;
    localparam int MODE_BOTH  = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy, init_done, sdio, sdenn, sclk, resetn;

    dac_sif_sequencer_if a_if ();
    dac_sif_sequencer_if b_if ();

    dac_sif_sequencer #(
        .CLK_DIV      (CLK_DIV),
        .RESET_CYCLES (RESET_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .a               (a_if),
        .b               (b_if),
        .busy            (busy),
        .init_done       (init_done),
        .DAC_CTRL_SDIO   (sdio),
        .DAC_CTRL_SDENN  (sdenn),
        .DAC_CTRL_SCLK   (sclk),
        .DAC_CTRL_RESETN (resetn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: everything is expressed as clk-edge numbers since reset release.
    int unsigned cyc;
    int unsigned next_free;
    int unsigned acc_edge;
    bit          last_served;
    bit          in_flight;
    bit          cur_port;
    logic [23:0] cur_frame;
    int          mode;
    int          accepts = 0;
    int          aborted = 0;
    int          frames  = 0;

    // Requester state.
    bit          req_valid [2];
    bit          req_acc   [2];
    logic [6:0]  req_addr  [2];
    logic [15:0] req_data  [2];

    // Frame decoder state.
    logic [23:0] cap;
    int          nbits;
    int          low_cnt;
    logic        prev_sclk;
    logic        prev_sdenn;
    logic [6:0]  alt_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        cyc         = 0;
        next_free   = 2 * RESET_CYCLES;
        last_served = 1'b1;
        in_flight   = 1'b0;
        cap         = '0;
        nbits       = 0;
        low_cnt     = 0;
        prev_sclk   = 1'b0;
        prev_sdenn  = 1'b1;
        alt_prev    = '0;
    endtask

    task automatic apply_inputs();
        a_if.valid = req_valid[0];
        a_if.addr  = req_addr[0];
        a_if.data  = req_data[0];
        b_if.valid = req_valid[1];
        b_if.addr  = req_addr[1];
        b_if.data  = req_data[1];
    endtask

    // Requester behaviour for the current mode; called at the falling edge.
    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (req_acc[p]) begin
                req_acc[p]   = 1'b0;
                req_valid[p] = 1'b0;
            end
            case (mode)
                MODE_RAND: begin
                    if (req_valid[p]) begin
                        if ($urandom_range(0, 47) == 0) req_valid[p] = 1'b0;
                    end else if ($urandom_range(0, 5) == 0) begin
                        req_valid[p] = 1'b1;
                        req_addr[p]  = 7'($urandom);
                        req_data[p]  = 16'($urandom);
                    end
                end
                MODE_BOTH: begin
                    if (!req_valid[p]) begin
                        req_valid[p] = 1'b1;
                        req_addr[p]  = 7'(p + 1);
                        req_data[p]  = 16'((p + 1) * 32'h1111);
                    end
                end
                default: ;
            endcase
        end
        apply_inputs();
    endtask

    // One clock period: check everything against the model, then advance over the rising edge.
    task automatic tick();
        bit          idle;
        bit          g;
        logic [1:0]  v;
        logic [1:0]  rdy;
        int unsigned j;
        logic        e_sdenn, e_sclk, e_sdio;
        #1;
        v    = {req_valid[1], req_valid[0]};
        idle = (cyc >= next_free);
        g    = (v == 2'b11) ? !last_served : v[1];
        rdy  = 2'b00;
        if (idle && (v != 2'b00)) rdy[g] = 1'b1;

        e_sdenn = 1'b1;
        e_sclk  = 1'b0;
        e_sdio  = 1'b0;
        if (in_flight) begin
            j = cyc - acc_edge;
            if (j >= 1 && j <= FRAME_LEN) begin
                e_sdenn = 1'b0;
                e_sclk  = 1'(((j - 1) / CLK_DIV) % 2);
                e_sdio  = cur_frame[23 - ((j - 1) / (2 * CLK_DIV))];
            end
        end

        check_eq("a_ready", a_if.ready, rdy[0]);
        check_eq("b_ready", b_if.ready, rdy[1]);
        check_eq("busy", busy, !idle);
        check_eq("init_done", init_done, cyc >= 2 * RESET_CYCLES);
        check_eq("resetn", resetn, cyc >= RESET_CYCLES);
        check_eq("sdenn", sdenn, e_sdenn);
        check_eq("sclk", sclk, e_sclk);
        check_eq("sdio", sdio, e_sdio);

        // Decode the frame off the pins, sampling SDIO while SCLK is high.
        if (!sdenn) begin
            low_cnt++;
            if (sclk && !prev_sclk) begin
                cap = {cap[22:0], sdio};
                nbits++;
            end
        end else if (!prev_sdenn) begin
            check_eq("frame_bits", nbits, 24);
            check_eq("frame_data", cap, cur_frame);
            check_eq("sdenn_low_len", low_cnt, FRAME_LEN);
            if (mode == MODE_BOTH) begin
                if (alt_prev != 7'd0) check_eq("alternate", cap[22:16] != alt_prev, 1);
                alt_prev = cap[22:16];
            end
            frames++;
            $display("frame %0d port %s addr 0x%02h data 0x%04h sdenn_low %0d",
                     frames, cur_port ? "B" : "A", cap[22:16], cap[15:0], low_cnt);
            cap     = '0;
            nbits   = 0;
            low_cnt = 0;
        end
        prev_sclk  = sclk;
        prev_sdenn = sdenn;

        @(posedge clk);
        if (rstn) begin
            cyc++;
            if (rdy != 2'b00) begin
                acc_edge     = cyc;
                in_flight    = 1'b1;
                cur_port     = g;
                cur_frame    = {1'b0, req_addr[g], req_data[g]};
                last_served  = g;
                next_free    = cyc + 1 + FRAME_LEN + GAP_CYCLES;
                req_acc[g]   = 1'b1;
                accepts++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            tick();
        end
    endtask

    // Let outstanding work drain with no new requests, within a cycle budget.
    task automatic drain(input string tag);
        int  budget;
        bit  reached;
        mode    = MODE_QUIET;
        budget  = 600;
        reached = 1'b0;
        while (budget > 0 && !reached) begin
            drive();
            tick();
            reached = (cyc >= next_free) && !req_valid[0] && !req_valid[1];
            budget--;
        end
        check_eq(tag, reached, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  budget;
        bit  hit;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            req_acc[p]   = 1'b0;
            req_addr[p]  = '0;
            req_data[p]  = '0;
        end
        mode = MODE_QUIET;
        model_reset();
        apply_inputs();
        @(negedge clk);

        // Single A write held pending through the reset sequence.
        req_valid[0] = 1'b1;
        req_addr[0]  = 7'h05;
        req_data[0]  = 16'hA5C3;
        apply_inputs();
        for (int i = 0; i < 3; i++) tick();
        rstn = 1'b1;
        drain("single_write_done");
        check_eq("single_write_frames", frames, 1);

        // Random requesters with drops and stalls.
        mode = MODE_RAND;
        run(3000);
        drain("rand_drain");

        // Both requesters continuously valid.
        mode = MODE_BOTH;
        run(1200);

        // Reset just after the 10th SCLK rise of a frame.
        budget = 1000;
        hit    = 1'b0;
        while (budget > 0 && !hit) begin
            drive();
            tick();
            hit = in_flight && ((cyc - acc_edge) == 19 * CLK_DIV + 2);
            budget--;
        end
        check_eq("midframe_reached", hit, 1);
        check_eq("midframe_sclk_high", sclk, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("rst_sdenn", sdenn, 1);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_sdio", sdio, 0);
        check_eq("rst_resetn", resetn, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_ready", {a_if.ready, b_if.ready}, 2'b00);
        aborted++;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive();
            tick();
        end
        rstn = 1'b1;
        run(1000);

        mode = MODE_RAND;
        run(1500);
        drain("final_drain");
        check_eq("frame_count", frames, accepts - aborted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
